// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - MMU register map, bus FSM states and queued request record
package mmu_pkg;

    localparam logic [15:0] MMU_CR   = 16'hD500;
    localparam logic [15:0] MMU_PCRA = 16'hD501;
    localparam logic [15:0] MMU_PCRB = 16'hD502;
    localparam logic [15:0] MMU_PCRC = 16'hD503;
    localparam logic [15:0] MMU_PCRD = 16'hD504;
    localparam logic [15:0] MMU_MCR  = 16'hD505;
    localparam logic [15:0] MMU_RCR  = 16'hD506;
    localparam logic [15:0] MMU_P0L  = 16'hD507;
    localparam logic [15:0] MMU_P0H  = 16'hD508;
    localparam logic [15:0] MMU_P1L  = 16'hD509;
    localparam logic [15:0] MMU_P1H  = 16'hD50A;
    localparam logic [15:0] MMU_VR   = 16'hD50B;
    localparam logic [15:0] MMU_LCR  = 16'hFF00;
    localparam logic [15:0] MMU_LCRA = 16'hFF01;
    localparam logic [15:0] MMU_LCRB = 16'hFF02;
    localparam logic [15:0] MMU_LCRC = 16'hFF03;
    localparam logic [15:0] MMU_LCRD = 16'hFF04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE
    } bus_state_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mmu_req_t;

    localparam int REQ_W = $bits(mmu_req_t);

endpackage

// File: rtl/mmu_req_fifo.sv
// rtl/mmu_req_fifo.sv - synchronous request FIFO; extra pointer bit separates full from empty
module mmu_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/mmu_bus_master.sv
// rtl/mmu_bus_master.sv - queued register requests turned into 8502-style bus cycles for the MMU
module mmu_bus_master
    import mmu_pkg::*;
#(
    parameter int          SETUP_CYCLES  = 1,
    parameter int          STROBE_CYCLES = 1,
    parameter int          FIFO_DEPTH    = 2,
    parameter logic [15:0] IDLE_ADDR     = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_addr,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_dout,
    output logic        bus_doe,
    input  logic [7:0]  bus_din,
    output logic        busy
);
    localparam int MAX_PHASE = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW        = $clog2(MAX_PHASE + 1);
    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);

    bus_state_t    r_state, w_next_state;
    logic [CW-1:0] r_cnt, w_next_cnt;
    mmu_req_t      w_head, w_new_req;
    logic          w_full, w_empty, w_pop, w_capture;

    logic [15:0]   r_bus_addr, w_next_addr;
    logic          r_bus_rw, w_next_rw;
    logic [7:0]    r_bus_dout, w_next_dout;
    logic          r_bus_doe, w_next_doe;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_addr;
    logic [7:0]    r_rsp_rdata;

    assign w_new_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

    mmu_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (req_valid),
        .i_wdata (w_new_req),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_addr  = r_bus_addr;
        w_next_rw    = r_bus_rw;
        w_next_dout  = r_bus_dout;
        w_next_doe   = r_bus_doe;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            // RELEASE behaves like IDLE for dispatch, giving one idle cycle between accesses
            ST_IDLE, ST_RELEASE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SETUP;
                    w_next_cnt   = SETUP_LOAD;
                    w_next_addr  = w_head.addr;
                    w_next_rw    = !w_head.we;
                    w_next_doe   = w_head.we;
                    if (w_head.we) w_next_dout = w_head.wdata;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_STROBE;
                    w_next_cnt   = STROBE_LOAD;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RELEASE;
                    w_next_cnt   = '0;
                    w_capture    = r_bus_rw;
                    w_next_addr  = IDLE_ADDR;
                    w_next_rw    = 1'b1;
                    w_next_doe   = 1'b0;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_addr  <= IDLE_ADDR;
            r_bus_rw    <= 1'b1;
            r_bus_dout  <= 8'h00;
            r_bus_doe   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= 16'h0000;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_bus_addr  <= w_next_addr;
            r_bus_rw    <= w_next_rw;
            r_bus_dout  <= w_next_dout;
            r_bus_doe   <= w_next_doe;
            r_rsp_valid <= w_capture;
            if (w_capture) begin
                r_rsp_addr  <= r_bus_addr;
                r_rsp_rdata <= bus_din;
            end
        end
    end

    assign req_ready = !w_full;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign bus_addr  = r_bus_addr;
    assign bus_rw    = r_bus_rw;
    assign bus_dout  = r_bus_dout;
    assign bus_doe   = r_bus_doe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mmu_bus_master.sv
// tb/tb_mmu_bus_master.sv - scoreboard bench: default-timing DUT (A) and 3/2-timing DUT (B)
`timescale 1ns/1ps
module tb_mmu_bus_master;
    import mmu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    logic        rst_a = 1'b1, vld_a, we_a, rdy_a, rspv_a, brw_a, bdoe_a, busy_a;
    logic [15:0] addr_a, rspa_a, baddr_a;
    logic [7:0]  wd_a, rspd_a, bdout_a, bdin_a;
    logic        rst_b = 1'b1, vld_b, we_b, rdy_b, rspv_b, brw_b, bdoe_b, busy_b;
    logic [15:0] addr_b, rspa_b, baddr_b;
    logic [7:0]  wd_b, rspd_b, bdout_b, din_b;

    mmu_bus_master u_dut_a (
        .clk(clk), .reset(rst_a), .req_valid(vld_a), .req_ready(rdy_a), .req_we(we_a),
        .req_addr(addr_a), .req_wdata(wd_a), .rsp_valid(rspv_a), .rsp_addr(rspa_a),
        .rsp_rdata(rspd_a), .bus_addr(baddr_a), .bus_rw(brw_a), .bus_dout(bdout_a),
        .bus_doe(bdoe_a), .bus_din(bdin_a), .busy(busy_a)
    );

    mmu_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(2)) u_dut_b (
        .clk(clk), .reset(rst_b), .req_valid(vld_b), .req_ready(rdy_b), .req_we(we_b),
        .req_addr(addr_b), .req_wdata(wd_b), .rsp_valid(rspv_b), .rsp_addr(rspa_b),
        .rsp_rdata(rspd_b), .bus_addr(baddr_b), .bus_rw(brw_b), .bus_dout(bdout_b),
        .bus_doe(bdoe_b), .bus_din(din_b), .busy(busy_b)
    );

    // Reference register space (updated in request order) and the bus-side device it is compared against
    logic [7:0] ref_mem [65536];
    logic [7:0] dev_mem [65536];
    assign bdin_a = dev_mem[baddr_a];

    typedef struct packed { logic we; logic [15:0] addr; logic [7:0] wdata; } acc_t;
    typedef struct packed { logic [15:0] addr; logic [7:0] data; } rsp_t;
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   starts_q[$];

    logic [15:0] addr_list [17] = '{MMU_CR, MMU_PCRA, MMU_PCRB, MMU_PCRC, MMU_PCRD, MMU_MCR,
        MMU_RCR, MMU_P0L, MMU_P0H, MMU_P1L, MMU_P1H, MMU_VR, MMU_LCR, MMU_LCRA, MMU_LCRB,
        MMU_LCRC, MMU_LCRD};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int last_acc_a, last_wait_a, last_acc_b;

    task automatic send_a(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        int n = 0;
        vld_a = 1'b1; we_a = we; addr_a = addr; wd_a = wd;
        while (!rdy_a && n < 100) begin @(negedge clk); n++; end
        last_wait_a = n;
        if (rdy_a) begin
            acc_q.push_back('{we, addr, wd});
            if (we) ref_mem[addr] = wd;
            else    rsp_q.push_back('{addr, ref_mem[addr]});
        end else begin
            check("req_ready_a_timeout", 32'(rdy_a), 32'd1);
            vld_a = 1'b0;
        end
        @(negedge clk);
        vld_a = 1'b0;
        last_acc_a = cyc;
    endtask

    task automatic send_b(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        int n = 0;
        vld_b = 1'b1; we_b = we; addr_b = addr; wd_b = wd;
        while (!rdy_b && n < 100) begin @(negedge clk); n++; end
        check("req_ready_b", 32'(rdy_b), 32'd1);
        @(negedge clk);
        vld_b = 1'b0;
        last_acc_b = cyc;
    endtask

    logic        in_run = 1'b0;
    int          run_len, rsp_seen_a = 0, last_rsp_a = 0;
    logic [15:0] run_addr;
    logic        run_rw, run_doe;
    logic [7:0]  run_dout;

    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while ((busy_a || in_run) && n < 200) begin @(negedge clk); n++; end
        check("idle_timeout_a", 32'(busy_a), 32'd0);
    endtask

    // Monitor for DUT A: groups contiguous non-idle bus cycles into accesses and scores them
    initial forever begin
        acc_t e;
        rsp_t r;
        @(negedge clk);
        if (rst_a) begin
            in_run = 1'b0;
        end else begin
            check("doe_with_rw_a", 32'(bdoe_a & brw_a), 32'd0);
            if (baddr_a != 16'h0000 || !brw_a || bdoe_a) begin
                if (!in_run) begin
                    in_run = 1'b1; run_len = 0;
                    run_addr = baddr_a; run_rw = brw_a; run_doe = bdoe_a; run_dout = bdout_a;
                    starts_q.push_back(cyc);
                    if (!brw_a) dev_mem[baddr_a] = bdout_a;
                end else begin
                    check("bus_stable_a", 32'({baddr_a, brw_a, bdoe_a, bdout_a}),
                          32'({run_addr, run_rw, run_doe, run_dout}));
                end
                run_len++;
            end else if (in_run) begin
                in_run = 1'b0;
                check("access_expected_a", 32'(acc_q.size() != 0), 32'd1);
                if (acc_q.size() != 0) begin
                    e = acc_q.pop_front();
                    check("bus_addr_a", 32'(run_addr), 32'(e.addr));
                    check("bus_rw_a", 32'(run_rw), 32'(!e.we));
                    check("bus_doe_a", 32'(run_doe), 32'(e.we));
                    if (e.we) check("bus_dout_a", 32'(run_dout), 32'(e.wdata));
                    check("access_len_a", 32'(run_len), 32'd2);
                end
            end
            if (rspv_a) begin
                rsp_seen_a++;
                last_rsp_a = cyc;
                check("rsp_expected_a", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    check("rsp_addr_a", 32'(rspa_a), 32'(r.addr));
                    check("rsp_rdata_a", 32'(rspd_a), 32'(r.data));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, n, maxw, cnt, pulses, pulse_k, bad;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'(i ^ (i >> 8));
            dev_mem[i] = 8'(i ^ (i >> 8));
        end
        vld_a = 1'b0; we_a = 1'b0; addr_a = '0; wd_a = '0;
        vld_b = 1'b0; we_b = 1'b0; addr_b = '0; wd_b = '0; din_b = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        check("reset_rsp_a", 32'({rspa_a, rspd_a, bdout_a}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_defaults_a", 32'({baddr_a, brw_a, bdoe_a, rdy_a, busy_a, rspv_a}),
                  32'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
        end

        send_a(1'b1, MMU_CR, 8'h55);
        wait_idle_a();
        r0 = rsp_seen_a;
        send_a(1'b0, MMU_CR, 8'h00);
        n = 0;
        while (rsp_seen_a == r0 && n < 20) begin @(negedge clk); n++; end
        check("read_latency_a", 32'(last_rsp_a - last_acc_a), 32'd3);
        repeat (4) @(negedge clk);
        check("rsp_pulse_once_a", 32'(rsp_seen_a - r0), 32'd1);
        check("cr_readback_a", 32'(dev_mem[MMU_CR]), 32'h55);

        wait_idle_a();
        starts_q.delete();
        maxw = 0;
        for (int i = 0; i < 4; i++) begin
            send_a(1'b1, MMU_PCRA + 16'(i), 8'(8'h10 + i));
            if (last_wait_a > maxw) maxw = last_wait_a;
        end
        check("fifo_backpressure_a", 32'(maxw > 0), 32'd1);
        wait_idle_a();
        check("b2b_count_a", 32'(starts_q.size()), 32'd4);
        if (starts_q.size() == 4)
            for (int i = 1; i < 4; i++)
                check("b2b_spacing_a", 32'(starts_q[i] - starts_q[i-1]), 32'd3);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_a(1'($urandom_range(0, 1)), addr_list[$urandom_range(0, 16)], 8'($urandom));
        end
        wait_idle_a();
        repeat (3) @(negedge clk);
        check("acc_q_drained", 32'(acc_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        // DUT B: read data must come only from the last strobe edge
        @(negedge clk);
        send_b(1'b0, MMU_LCR, 8'h00);
        cnt = 0; pulses = 0; pulse_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (baddr_b == MMU_LCR && brw_b && !bdoe_b) cnt++;
            if (rspv_b) begin
                pulses++; pulse_k = k;
                check("rsp_rdata_b", 32'(rspd_b), 32'h3F);
                check("rsp_addr_b", 32'(rspa_b), 32'(MMU_LCR));
            end
            din_b = (k == 5) ? 8'h3F : (8'hC0 | 8'(k));
            @(negedge clk);
        end
        check("addr_stable_cycles_b", 32'(cnt), 32'd5);
        check("rsp_pulses_b", 32'(pulses), 32'd1);
        check("rsp_latency_b", 32'(pulse_k), 32'd6);

        // DUT B: reset in the second SETUP cycle of a write, with a second write queued
        send_b(1'b1, MMU_MCR, 8'hAA);
        send_b(1'b1, MMU_RCR, 8'h5C);
        @(negedge clk);
        check("write_in_setup_b", 32'({baddr_b, brw_b, bdoe_b, bdout_b}),
              32'({MMU_MCR, 1'b0, 1'b1, 8'hAA}));
        rst_b = 1'b1;
        @(negedge clk);
        check("reset_bus_b", 32'({baddr_b, brw_b, bdoe_b, bdout_b}),
              32'({16'h0000, 1'b1, 1'b0, 8'h00}));
        check("reset_rsp_b", 32'({rspv_b, rspa_b, rspd_b}), 32'd0);
        check("reset_flags_b", 32'({rdy_b, busy_b}), 32'd2);
        rst_b = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (baddr_b != 16'h0000 || !brw_b || bdoe_b || rspv_b || busy_b) bad++;
        end
        check("queue_discarded_b", 32'(bad), 32'd0);
        din_b = 8'h5A;
        send_b(1'b0, MMU_LCRA, 8'h00);
        cnt = 0; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (baddr_b == MMU_LCRA && brw_b) cnt++;
            if (rspv_b) begin
                pulses++;
                check("fresh_rdata_b", 32'({rspa_b, rspd_b}), 32'({MMU_LCRA, 8'h5A}));
            end
            @(negedge clk);
        end
        check("fresh_addr_cycles_b", 32'(cnt), 32'd5);
        check("fresh_pulses_b", 32'(pulses), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
